// File: rtl/paddle_ctrl.sv
// Paddle controller for VGA pong: debounced buttons or ball auto-track
// drive the bottom (x) and top (x2) paddle left edges on a periodic move tick.
module paddle_ctrl #(
    parameter int T_TICK     = 500_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int STEP       = 2,
    parameter int STICK      = 100,
    parameter int VGA_XDIS   = 800,
    parameter int SIDE       = 40,
    parameter int DEAD       = 4,
    parameter int X_RESET    = 350
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn2_l,
    input  logic       btn2_r,
    input  logic       auto2,
    input  logic [9:0] ball_x,
    output logic [9:0] x,
    output logic [9:0] x2,
    output logic       tick
);

    localparam int X_MAX = VGA_XDIS - STICK;
    localparam int TW    = (T_TICK > 1) ? $clog2(T_TICK) : 1;
    localparam int DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [9:0]    STEP_W = 10'(STEP);
    localparam logic [9:0]    XMAX_W = 10'(X_MAX);
    localparam logic [9:0]    XHI_W  = 10'(X_MAX - STEP);
    localparam logic [9:0]    XRST_W = 10'(X_RESET);
    localparam logic [TW-1:0] TEND   = TW'(T_TICK - 1);
    localparam logic [DW-1:0] DEND   = DW'(DEB_CYCLES - 1);

    // Button order: {btn2_r, btn2_l, btn_r, btn_l}
    logic [3:0]         btn_raw;
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         acc_q, acc_d;
    logic [3:0][DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [9:0]         x_q, x_d, x2_q, x2_d;
    logic [10:0]        tgt_c, ctr_c;
    logic               al_c, ar_c, l2_c, r2_c;

    assign btn_raw = {btn2_r, btn2_l, btn_r, btn_l};

    function automatic logic [9:0] step_pos(
        input logic [9:0] p,
        input logic       l,
        input logic       r
    );
        step_pos = p;
        if (l && !r) begin
            step_pos = (p < STEP_W) ? 10'd0 : p - STEP_W;
        end else if (r && !l) begin
            step_pos = (p > XHI_W) ? XMAX_W : p + STEP_W;
        end
    endfunction

    always_comb begin
        acc_d  = acc_q;
        dcnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
                if (dcnt_q[i] == DEND) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick   = (tcnt_q == TEND);
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

    // 11-bit centres so ball_x near the right edge cannot wrap
    assign tgt_c = {1'b0, ball_x} + 11'(SIDE / 2);
    assign ctr_c = {1'b0, x2_q} + 11'(STICK / 2);
    assign ar_c  = tgt_c > (ctr_c + 11'(DEAD));
    assign al_c  = (tgt_c + 11'(DEAD)) < ctr_c;
    assign l2_c  = auto2 ? al_c : acc_q[2];
    assign r2_c  = auto2 ? ar_c : acc_q[3];

    always_comb begin
        x_d  = x_q;
        x2_d = x2_q;
        if (tick) begin
            x_d  = step_pos(x_q, acc_q[0], acc_q[1]);
            x2_d = step_pos(x2_q, l2_c, r2_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            x_q     <= XRST_W;
            x2_q    <= XRST_W;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
        end
    end

    assign x  = x_q;
    assign x2 = x2_q;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Paddle controller for the VGA pong game. It produces the two paddle positions that the ball-motion block consumes: bottom paddle `x` and top paddle `x2`. Each value is the left edge of a 100-pixel paddle on the 800-pixel-wide screen. Inputs are raw push-buttons, which are synchronised and debounced. The top paddle can instead auto-track the ball position returned by the ball-motion block. Positions change only on a periodic move tick, so paddle speed is independent of the clock.

## Interface
- `T_TICK`, 500_000: clock cycles per move tick (10 ms at 50 MHz).
- `DEB_CYCLES`, 500_000: cycles a synchronised button level must be stable before it is accepted.
- `STEP`, 2: pixels moved per tick.
- `STICK`, 100: paddle width in pixels.
- `VGA_XDIS`, 800: visible screen width.
- `SIDE`, 40: ball side length, used for the ball centre.
- `DEAD`, 4: auto-track dead band in pixels.
- `X_RESET`, 350: reset position of both paddles.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_l`, `btn_r` in 1: raw bottom-paddle buttons, active-high, asynchronous to `clk`.
- `btn2_l`, `btn2_r` in 1: raw top-paddle buttons, same properties.
- `auto2` in 1: 1 selects auto-track for the top paddle. Sampled on each tick.
- `ball_x` in 10: ball left edge from the ball-motion block.
- `x` out 10: bottom paddle left edge.
- `x2` out 10: top paddle left edge.
- `tick` out 1: one-cycle move strobe.

## Operation
- X_MAX = VGA_XDIS − STICK (700 by default). X_MIN = 0.
- Synchroniser: each raw button passes through 2 flip-flops.
- Debouncer: one per button, each with its own counter.
  - A synchronised value that differs from the accepted value increments the counter.
  - When the counter reaches DEB_CYCLES−1, the accepted value updates on the next edge and the counter clears.
  - Any cycle where the synchronised value equals the accepted value clears the counter.
- Tick counter: runs 0 → T_TICK−1 and wraps to 0. `tick` = 1 exactly when count == T_TICK−1.
- Bottom paddle, on tick, using the debounced levels L and R:
  - L only: x ← (x < X_MIN+STEP) ? X_MIN : x−STEP.
  - R only: x ← (x > X_MAX−STEP) ? X_MAX : x+STEP.
  - Both or neither: hold.
- Top paddle, manual (`auto2` = 0): same rules using `btn2_l`/`btn2_r`.
- Top paddle, auto (`auto2` = 1): buttons are ignored.
  - Target centre t = ball_x + SIDE/2. Paddle centre p = x2 + STICK/2.
  - Compute both in 11 bits so the sum never wraps.
  - If t > p+DEAD, move right by STEP. If t+DEAD < p, move left by STEP. Otherwise hold.
  - Clamping is identical to manual mode.
- Positions never leave [X_MIN, X_MAX], including when STEP does not divide the range.

## Timing
- Reset values: x = x2 = X_RESET; `tick` = 0; tick counter = 0; synchronisers, accepted levels and debounce counters = 0.
- Button-to-accept latency: 2 sync cycles + DEB_CYCLES cycles after a clean edge. A pulse shorter than DEB_CYCLES synchronised cycles is never accepted.
- Position registers update on the edge that ends the `tick` cycle. The new value is visible in the cycle after `tick`, then held until the next tick.
- `ball_x` and `auto2` are sampled combinationally in the tick cycle only.
- A debounced change landing in the same cycle as `tick` uses the previously accepted level.
- Reset asserted mid-operation returns all state to reset values on the next edge, regardless of tick phase.
- First tick after reset release: cycle T_TICK−1.

## Test plan
All scenarios use T_TICK=10, DEB_CYCLES=4, STEP=5, other parameters at default.
- **Reset:** hold `rst` for 3 cycles, then release. → x = x2 = 350, `tick` = 0. First `tick` in cycle 9 after release, then every 10 cycles.
- **Bottom paddle left run:** hold `btn_l` = 1 steadily. → accepted after 6 cycles; x decreases by 5 per tick; reaches 0 after 70 ticks and stays 0. Repeat with `btn_r`: saturates at 700, never 701+.
- **Glitch rejection:** pulse `btn_r` high for 3 cycles. → x unchanged for 100 cycles. Both buttons held → x holds at 350.
- **Auto-track:** auto2=1, ball_x=600. → x2 rises by 5 per tick until 570 (centres equal at 620), then holds. Change ball_x to 780. → x2 stops at 700. Top buttons toggling during this have no effect.
- **Dead band:** auto2=1, x2=350, ball_x=333 (t=353, p=400, |diff| = 47). → moves left. At x2 = 315 (p=365, within ±4 of 353 is false until x2 = 305, p=355). → holds at 305.
- **Reset mid-run:** assert `rst` while x = 120 with `btn_r` held. → next edge x = 350 and the debounce restarts. First accepted press needs the full 6 cycles again.
